data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the CPU's data-memory port. Serves word reads and writes from an internal array behind a valid/ready request channel and a valid/ready response channel.
- Has a fixed, parameterised access latency; the CPU stalls on handshakes.
- Checks alignment and range, and flags faulting accesses instead of performing them.
- Sits between the datapath's memory-address/write-data outputs and its memory read-data input.

Parameters:
- ADDR_BITS, 10, word-address width; array depth = 2^ADDR_BITS 32-bit words.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and array access (0 allowed).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- req_ready  out  1  responder can accept a request
- resp_valid  out  1  response present
- resp_ready  in  1  CPU accepts the response
- resp_rdata  out  32  read data (0 for writes and errors)
- resp_err  out  1  misaligned or out-of-range access
- busy  out  1  a transaction is in flight (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE, wait counter = 0, latched request cleared.
  - resp_valid=0, resp_rdata=0, resp_err=0, busy=0. req_ready=1 once rst deasserts.
  - The memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance happens on an edge with req_valid=1. At that edge the responder latches addr, wdata and write, loads the counter with WAIT_CYCLES, and moves to WAIT.
- Error check (on the latched address): err = (addr[1:0] != 0) OR (addr[31:ADDR_BITS+2] != 0).
- WAIT:
  - req_ready=0.
  - Each edge: if counter != 0, decrement; if counter == 0, perform the access and move to RESP.
  - The access edge is therefore exactly WAIT_CYCLES+1 edges after the acceptance edge.
- Access:
  - Word index = addr[ADDR_BITS+1:2].
  - Read: resp_rdata <= mem[index].
  - Write: mem[index] <= wdata, resp_rdata <= 0.
  - err=1: no array write, resp_rdata <= 0, resp_err <= 1. Otherwise resp_err <= 0.
- RESP:
  - resp_valid=1. resp_rdata and resp_err stay stable until the handshake.
  - On an edge with resp_ready=1, clear resp_valid and return to IDLE.
  - resp_ready is ignored outside RESP.
- req_valid during WAIT/RESP is ignored; no queuing. The requester must hold the request until req_ready.
- Minimum period between acceptances is WAIT_CYCLES+3 cycles when resp_ready is held high.
- Read-after-write to the same address returns the new data.
- Reset mid-transaction: the pending access is aborted. A write not yet at its access edge never reaches the array.
- Width rules:
  - Upper address bits are checked, never truncated silently.
  - The counter width is clog2(WAIT_CYCLES+1), minimum 1 bit.

Optional Feature:
- Macro MEM_BYTE_WRITE_EN.
- Defined:
  - Adds input port req_be[3:0]. On a non-error write, lane i (bits 8i+7:8i) is written only if req_be[i]=1.
  - req_be=0000 is a legal no-op write, with resp_err=0.
  - Reads ignore req_be. Alignment rules are unchanged (word-aligned only).
- Undefined: no req_be port; every non-error write updates all 32 bits.

Decomposition:
- Package data_mem_pkg holds:
  - the FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - the word width constant (32);
  - the byte-lane count (4).
- One natural sub-module, wait_state_counter: a loadable down-counter with a zero flag. It is parameterised by WAIT_CYCLES and reused for other slow peripherals.
- The array and FSM stay in data_mem_responder.

Test Plan:
- Reset then idle: rst=0 -> all outputs 0. Release rst -> req_ready=1, busy=0.
- Write then read (WAIT_CYCLES=2):
  - Write 0xDEADBEEF to 0x00000010, accepted at edge E0 -> resp_valid rises after E3 with rdata=0 and err=0.
  - Read of 0x10 -> rdata=0xDEADBEEF, err=0, resp_valid rising 3 edges after acceptance.
- Faults:
  - Read 0x00000012 -> resp_err=1, rdata=0.
  - Write 0x00001000 (ADDR_BITS=10) -> resp_err=1; a following read of 0x00000000 shows the word unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, rdata and err stable, req_ready=0, and a new req_valid is not accepted. Raise resp_ready -> IDLE next cycle.
- Reset mid-write: accept a write of 0x12345678 to 0x20, pull rst low during WAIT -> the later read of 0x20 returns the prior contents.
- Byte lanes (MEM_BYTE_WRITE_EN defined): word 0x11223344 at 0x30, write 0xAABBCCDD with be=0101 -> read returns 0x11BB33DD.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory responder and its helpers.
package data_mem_pkg;

    localparam int WORD_W = 32;
    localparam int LANES  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wait_state_counter.sv
// Loadable down-counter with a zero flag; holds at zero once it gets there.
module wait_state_counter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(WAIT_CYCLES);
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: word array behind valid/ready request and response channels.
// Optional per-byte write enables when MEM_BYTE_WRITE_EN is defined.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
`ifdef MEM_BYTE_WRITE_EN
    input  logic [LANES-1:0]  req_be,
`endif
    output logic              req_ready,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_BITS;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic [LANES-1:0]    be_q, be_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [ADDR_BITS-1:0] idx;
    logic [LANES-1:0]    be_in;
    logic [WORD_W-1:0]   merged;
    logic                addr_err, cnt_load, cnt_zero, access, mem_we;

`ifdef MEM_BYTE_WRITE_EN
    assign be_in = req_be;
`else
    assign be_in = '1;
`endif

    wait_state_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
        .clk   (clk),
        .rst_n (rst),
        .load  (cnt_load),
        .dec   (state_q == WAIT),
        .zero  (cnt_zero)
    );

    // Upper bits are checked rather than dropped so aliasing addresses fault.
    assign idx      = addr_q[ADDR_BITS+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_BITS + 2)) != '0);
    assign access   = (state_q == WAIT) && cnt_zero;
    assign mem_we   = access && write_q && !addr_err;

    always_comb begin
        merged = mem[idx];
        for (int i = 0; i < LANES; i++) begin
            if (be_q[i]) begin
                merged[8*i +: 8] = wdata_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        write_d  = write_q;
        be_d     = be_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    write_d  = req_write;
                    be_d     = be_in;
                    cnt_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    err_d   = addr_err;
                    rdata_d = (write_q || addr_err) ? '0 : mem[idx];
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // The array has no reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= merged;
        end
    end

    assign req_ready  = rst && (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder with a transaction-level memory model.
module tb_data_mem_responder;

    localparam int AB    = 10;
    localparam int W     = 2;
    localparam int DEPTH = 1 << AB;
`ifdef MEM_BYTE_WRITE_EN
    localparam bit BE_EN = 1'b1;
`else
    localparam bit BE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err, busy;
    logic [31:0] resp_rdata;

    int n_chk = 0;
    int n_err = 0;
    bit run   = 1'b0;

    data_mem_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
`ifdef MEM_BYTE_WRITE_EN
        .req_be     (req_be),
`endif
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: memory contents, per-byte "known" flags, one outstanding request.
    logic [31:0] m_mem [DEPTH];
    bit   [3:0]  m_kn  [DEPTH];
    bit          m_busy = 1'b0;
    bit          m_rv   = 1'b0;
    logic [31:0] m_rd   = '0;
    logic [31:0] m_mask = '1;
    bit          m_err  = 1'b0;
    int          cyc    = 0;
    int          m_t    = 0;
    logic [31:0] ma, md;
    bit          mw;
    logic [3:0]  mbe;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_rv   = 1'b0;
            m_rd   = '0;
            m_mask = '1;
            m_err  = 1'b0;
        end else begin
            cyc++;
            if (!m_busy) begin
                if (req_valid) begin
                    m_busy = 1'b1;
                    m_t    = cyc + W + 1;
                    ma     = req_addr;
                    md     = req_wdata;
                    mw     = req_write;
                    mbe    = BE_EN ? req_be : 4'hF;
                end
            end else if (!m_rv) begin
                if (cyc == m_t) begin
                    m_err  = (ma[1:0] != 2'b00) || (ma >= 32'(DEPTH * 4));
                    m_rd   = '0;
                    m_mask = '1;
                    if (!m_err) begin
                        int i;
                        i = int'(ma >> 2);
                        if (mw) begin
                            for (int b = 0; b < 4; b++) begin
                                if (mbe[b]) begin
                                    m_mem[i][8*b +: 8] = md[8*b +: 8];
                                    m_kn[i][b]         = 1'b1;
                                end
                            end
                        end else begin
                            m_rd = m_mem[i];
                            for (int b = 0; b < 4; b++) m_mask[8*b +: 8] = {8{m_kn[i][b]}};
                        end
                    end
                    m_rv = 1'b1;
                end
            end else if (resp_ready) begin
                m_rv   = 1'b0;
                m_busy = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk1("req_ready", req_ready, rst && !m_busy);
            chk1("busy", busy, m_busy);
            chk1("resp_valid", resp_valid, m_rv);
            if (!rst || m_rv) begin
                chk32("resp_rdata", resp_rdata & m_mask, m_rd & m_mask);
                chk1("resp_err", resp_err, m_err);
            end
        end
    end

    task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input int hold, input bit poke,
                       output logic [31:0] rd, output bit er, output int lat);
        bit acc;
        bit got;
        int n;
        rd = '0; er = 1'b0; lat = 0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
        resp_ready = 1'b0;
        acc = 1'b0; n = 0;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            n++;
        end
        #1 req_valid = 1'b0;
        if (!acc) begin
            n_chk++; n_err++;
            $display("FAIL accept_timeout: request at %h not accepted within 40 cycles", a);
            return;
        end
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = resp_valid;
        end
        if (!got) begin
            n_chk++; n_err++;
            $display("FAIL resp_timeout: no response within 40 cycles for %h", a);
            return;
        end
        rd = resp_rdata;
        er = resp_err;
        if (poke) begin
            req_valid = 1'b1; req_write = 1'($urandom); req_addr = $urandom & 32'hFC;
        end
        repeat (hold) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    logic [31:0] rd;
    bit          er;
    int          lat;

    initial begin
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_be = 4'hF; resp_ready = 0;
        rst = 1'b1;
        #1 rst = 1'b0;
        run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_rdata", resp_rdata, 32'h0);
        chk1("rst_err", resp_err, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk1("rel_req_ready", req_ready, 1'b1);
        chk1("rel_busy", busy, 1'b0);
        @(posedge clk); #1;

        txn(1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, rd, er, lat);
        chk32("wr10_lat", lat, 3); chk32("wr10_rdata", rd, 0); chk1("wr10_err", er, 0);
        txn(0, 32'h10, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk32("rd10_lat", lat, 3); chk32("rd10_rdata", rd, 32'hDEADBEEF); chk1("rd10_err", er, 0);
        txn(0, 32'h12, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk32("rd12_rdata", rd, 0); chk1("rd12_err", er, 1);
        txn(1, 32'h0, 32'hCAFEF00D, 4'hF, 0, 0, rd, er, lat);
        txn(1, 32'h1000, 32'h55555555, 4'hF, 0, 0, rd, er, lat);
        chk1("wr1000_err", er, 1); chk32("wr1000_rdata", rd, 0);
        txn(0, 32'h0, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk32("rd0_rdata", rd, 32'hCAFEF00D); chk1("rd0_err", er, 0);

        // Backpressure with a competing request held on the request channel.
        txn(0, 32'h10, 32'h0, 4'hF, 5, 1, rd, er, lat);
        chk32("bp_rdata", rd, 32'hDEADBEEF);
        chk1("bp_idle_busy", busy, 1'b0);
        chk1("bp_idle_ready", req_ready, 1'b1);

        // Reset during the wait states of a write.
        txn(1, 32'h20, 32'h0BADF00D, 4'hF, 0, 0, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
        @(negedge clk);
        chk1("mid_acc_ready", req_ready, 1'b1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        txn(0, 32'h20, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk32("mid_rst_rdata", rd, 32'h0BADF00D); chk1("mid_rst_err", er, 0);

`ifdef MEM_BYTE_WRITE_EN
        txn(1, 32'h30, 32'h11223344, 4'hF, 0, 0, rd, er, lat);
        txn(1, 32'h30, 32'hAABBCCDD, 4'b0101, 0, 0, rd, er, lat);
        chk1("be_wr_err", er, 0);
        txn(1, 32'h30, 32'hFFFFFFFF, 4'b0000, 0, 0, rd, er, lat);
        chk1("be_noop_err", er, 0);
        txn(0, 32'h30, 32'h0, 4'hF, 0, 0, rd, er, lat);
        chk32("be_rdata", rd, 32'h11BB33DD);
`endif

        for (int k = 0; k < 250; k++) begin
            logic [31:0] a;
            int r;
            r = $urandom_range(0, 9);
            if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
            else if (r == 7) a = $urandom & 32'h0000_0FFC;
            else if (r == 8) a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
            else             a = $urandom;
            txn(1'($urandom), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), 1'($urandom), rd, er, lat);
            chk32("rand_lat", lat, W + 1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
